// File: rtl/instr_encoder_loader_if.sv
// Request/instruction-memory bundle for the instruction encoder-loader.
// Master drives requests and start; slave returns ready, memory writes and status.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [3:0]        in_cond;
  logic              in_imm;
  logic              in_s;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [23:0]       in_operand;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              done;
  logic              err_illegal;

  modport master (
    output start, in_valid, in_op, in_cond, in_imm, in_s, in_rn, in_rd, in_operand, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_count, full, done, err_illegal
  );

  modport slave (
    input  start, in_valid, in_op, in_cond, in_imm, in_s, in_rn, in_rd, in_operand, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, word_count, full, done, err_illegal
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic ops into ARM words and writes them to consecutive imem addresses.
// Write strobe 1 cycle after accept; 1 word per 2 cycles; ready drops while writing, done or full.
module instr_encoder_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  instr_encoder_loader_if.slave  io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t          r_state, w_state_nxt;
  logic [ADDR_W:0] r_count, w_count_nxt, w_count_inc;
  logic [31:0]     r_wdata, w_enc;
  logic            r_last, r_err;
  logic            w_full, w_accept, w_illegal;
  logic            w_dp, w_test, w_move, w_s;
  logic [3:0]      w_opc, w_rn, w_rd;

  assign w_full      = (r_count == DEPTH_C);
  assign w_accept    = io_bus.in_valid && io_bus.in_ready;
  assign w_illegal   = (io_bus.in_op == 4'd15);
  assign w_count_inc = r_count + ONE_C;

  // CMP/TST always set flags and have no destination; MOV/MVN have no first operand.
  assign w_test = (io_bus.in_op == 4'd10) || (io_bus.in_op == 4'd11);
  assign w_move = (io_bus.in_op == 4'd1)  || (io_bus.in_op == 4'd2);
  assign w_s    = io_bus.in_s | w_test;
  assign w_rn   = w_move ? 4'd0 : io_bus.in_rn;
  assign w_rd   = w_test ? 4'd0 : io_bus.in_rd;

  always_comb begin
    w_enc = '0;
    w_opc = '0;
    w_dp  = 1'b0;
    case (io_bus.in_op)
      4'd1:  begin w_dp = 1'b1; w_opc = 4'b1101; end
      4'd2:  begin w_dp = 1'b1; w_opc = 4'b1111; end
      4'd3:  begin w_dp = 1'b1; w_opc = 4'b0100; end
      4'd4:  begin w_dp = 1'b1; w_opc = 4'b0101; end
      4'd5:  begin w_dp = 1'b1; w_opc = 4'b0010; end
      4'd6:  begin w_dp = 1'b1; w_opc = 4'b0110; end
      4'd7:  begin w_dp = 1'b1; w_opc = 4'b0000; end
      4'd8:  begin w_dp = 1'b1; w_opc = 4'b1100; end
      4'd9:  begin w_dp = 1'b1; w_opc = 4'b0001; end
      4'd10: begin w_dp = 1'b1; w_opc = 4'b1010; end
      4'd11: begin w_dp = 1'b1; w_opc = 4'b1000; end
      4'd12, 4'd13:
        w_enc = {io_bus.in_cond, 2'b01, 1'b0, 4'b0100, (io_bus.in_op == 4'd12),
                 io_bus.in_rn, io_bus.in_rd, io_bus.in_operand[11:0]};
      4'd14:
        w_enc = {io_bus.in_cond, 3'b101, 1'b0, io_bus.in_operand};
      default: ;
    endcase
    if (w_dp) begin
      w_enc = {io_bus.in_cond, 2'b00, io_bus.in_imm, w_opc, w_s, w_rn, w_rd,
               io_bus.in_operand[11:0]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) w_count_nxt = '0;
        if (w_accept && !w_illegal) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_count_nxt = w_count_inc;
        w_state_nxt = (r_last || (w_count_inc == DEPTH_C)) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (io_bus.start) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_accept && !w_illegal) begin
        r_wdata <= w_enc;
        r_last  <= io_bus.in_last;
      end
      if (w_accept && w_illegal) r_err <= 1'b1;
    end
  end

  assign io_bus.in_ready    = (r_state == S_IDLE) && !w_full;
  assign io_bus.imem_we     = (r_state == S_WRITE);
  assign io_bus.imem_addr   = r_count[ADDR_W-1:0];
  assign io_bus.imem_wdata  = r_wdata;
  assign io_bus.word_count  = r_count;
  assign io_bus.full        = w_full;
  assign io_bus.done        = (r_state == S_DONE);
  assign io_bus.err_illegal = r_err;
endmodule
